// File: rtl/multi_dataflow_mac_mdc_pkg.sv
// Shared types for the MAC engine controller: FSM state encoding and counter width default.
package multi_dataflow_mac_mdc_package;

  localparam int CNT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/multi_dataflow_mac_mdc_out_reg.sv
// One-entry valid/ready slice holding a kernel result until the sink takes it.
module multi_dataflow_mac_mdc_out_reg #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         drop_i,
  input  logic         en_i,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  // Loads stall on en_i; the held entry still drains.
  assign in_ready_o  = en_i & (~valid_q | out_ready_i);
  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (drop_i) begin
      valid_d = 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/multi_dataflow_mac_mdc_engine_ctrl.sv
// Engine controller: joins three operand streams into the kernel, registers kernel
// results toward the sink, and counts output beats against a per-job limit.
module multi_dataflow_mac_mdc_engine_ctrl
  import multi_dataflow_mac_mdc_package::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  ctrl_start_i,
  input  logic                  ctrl_clear_i,
  input  logic                  ctrl_enable_i,
  input  logic [CNT_WIDTH-1:0]  cnt_limit_i,
  input  logic [DATA_WIDTH-1:0] in0_data_i,
  input  logic                  in0_valid_i,
  output logic                  in0_ready_o,
  input  logic [DATA_WIDTH-1:0] in1_data_i,
  input  logic                  in1_valid_i,
  output logic                  in1_ready_o,
  input  logic [DATA_WIDTH-1:0] in2_data_i,
  input  logic                  in2_valid_i,
  output logic                  in2_ready_o,
  output logic [DATA_WIDTH-1:0] k_data0_o,
  output logic [DATA_WIDTH-1:0] k_data1_o,
  output logic [DATA_WIDTH-1:0] k_data2_o,
  output logic                  k_valid_o,
  input  logic                  k_ready_i,
  input  logic [DATA_WIDTH-1:0] k_out_data_i,
  input  logic                  k_out_valid_i,
  output logic                  k_out_ready_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  flags_ready_o,
  output logic [CNT_WIDTH-1:0]  flags_cnt_o,
  output logic                  flags_done_o
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] limit_q, limit_d;
  logic                 run, beat, drop, soft_rst;

  assign soft_rst = rst_i | clear_i;
  assign run      = (state_q == ST_RUN);
  assign beat     = out_valid_o & out_ready_i;

  // All three operands move together or not at all.
  assign k_valid_o   = run & ctrl_enable_i & in0_valid_i & in1_valid_i & in2_valid_i;
  assign in0_ready_o = k_valid_o & k_ready_i;
  assign in1_ready_o = k_valid_o & k_ready_i;
  assign in2_ready_o = k_valid_o & k_ready_i;
  assign k_data0_o   = in0_data_i;
  assign k_data1_o   = in1_data_i;
  assign k_data2_o   = in2_data_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    limit_d = limit_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_clear_i) begin
          cnt_d = '0;
        end else if (ctrl_start_i) begin
          limit_d = cnt_limit_i;
          cnt_d   = '0;
          state_d = (cnt_limit_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (ctrl_clear_i) begin
          state_d = ST_IDLE;
        end else if (beat) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_d == limit_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (ctrl_clear_i) cnt_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Leaving RUN (abort or last beat) discards any result beyond the job.
  assign drop = run & (state_d != ST_RUN);

  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
    end
  end

  multi_dataflow_mac_mdc_out_reg #(.W(DATA_WIDTH)) u_out_reg (
    .clk_i       (clk_i),
    .rst_i       (soft_rst),
    .drop_i      (drop),
    .en_i        (run & ctrl_enable_i),
    .in_data_i   (k_out_data_i),
    .in_valid_i  (k_out_valid_i),
    .in_ready_o  (k_out_ready_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  assign flags_ready_o = (state_q == ST_IDLE);
  assign flags_done_o  = (state_q == ST_DONE);
  assign flags_cnt_o   = cnt_q;

endmodule

// File: tb/tb_multi_dataflow_mac_mdc_engine_ctrl.sv
// Bench for the engine controller: job-level reference model plus directed job scenarios.
module tb_multi_dataflow_mac_mdc_engine_ctrl;

  logic        clk = 1'b0;
  logic        rst, clr, cstart, cclr, cen, oready;
  logic [15:0] climit;
  logic        in_valid [3];
  logic [31:0] in_data  [3];
  logic        in_ready [3];
  logic [31:0] kd0, kd1, kd2, kod, odata;
  logic        kv, kr, kov, kor, ovalid, f_ready, f_done;
  logic [15:0] f_cnt;

  int tests = 0, fails = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  multi_dataflow_mac_mdc_engine_ctrl dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr),
    .ctrl_start_i(cstart), .ctrl_clear_i(cclr), .ctrl_enable_i(cen), .cnt_limit_i(climit),
    .in0_data_i(in_data[0]), .in0_valid_i(in_valid[0]), .in0_ready_o(in_ready[0]),
    .in1_data_i(in_data[1]), .in1_valid_i(in_valid[1]), .in1_ready_o(in_ready[1]),
    .in2_data_i(in_data[2]), .in2_valid_i(in_valid[2]), .in2_ready_o(in_ready[2]),
    .k_data0_o(kd0), .k_data1_o(kd1), .k_data2_o(kd2), .k_valid_o(kv), .k_ready_i(kr),
    .k_out_data_i(kod), .k_out_valid_i(kov), .k_out_ready_o(kor),
    .out_data_o(odata), .out_valid_o(ovalid), .out_ready_i(oready),
    .flags_ready_o(f_ready), .flags_cnt_o(f_cnt), .flags_done_o(f_done)
  );

  // Stream sources: each advances its own sequence only when a beat is taken.
  int idx [3] = '{0, 0, 0};
  always @(posedge clk)
    for (int n = 0; n < 3; n++)
      if (in_valid[n] && in_ready[n]) idx[n] <= idx[n] + 1;
  always_comb
    for (int n = 0; n < 3; n++) in_data[n] = 32'((n + 1) * 1000 + idx[n]);

  // Kernel: combinational sum, accepts exactly one job's worth of operands.
  int kiss = 0, kmax = 0;
  always @(posedge clk) begin
    if (rst || clr) begin kiss <= 0; kmax <= 0; end
    else if (f_ready && cstart && !cclr) begin kiss <= 0; kmax <= int'(climit); end
    else if (kv && kr) kiss <= kiss + 1;
  end
  assign kr  = kor & (kiss < kmax);
  assign kov = kv & kr;
  assign kod = kd0 + kd1 + kd2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: job phase 0=idle 1=running 2=done, beats counted, one held result.
  int ph = 0, mcnt = 0, mlim = 0, miss = 0;
  bit mov = 0;
  logic [31:0] mod = '0;
  int n_join [3] = '{0, 0, 0};
  int n_beat = 0, n_done = 0;

  always @(negedge clk) begin
    bit run, ekv, kl, bt;
    run = (ph == 1);
    ekv = run && cen && in_valid[0] && in_valid[1] && in_valid[2];
    if (chk_en) begin
      chk("ready", f_ready, ph == 0);
      chk("done", f_done, ph == 2);
      chk("cnt", f_cnt, mcnt);
      chk("out_valid", ovalid, mov);
      chk("out_data", odata, mod);
      chk("k_valid", kv, ekv);
      chk("k_out_ready", kor, run && cen && (!mov || oready));
      for (int n = 0; n < 3; n++) chk("in_ready", in_ready[n], ekv && kr);
      chk("k_data0", kd0, in_data[0]);
      chk("k_data1", kd1, in_data[1]);
      chk("k_data2", kd2, in_data[2]);
      for (int n = 0; n < 3; n++) if (in_valid[n] && in_ready[n]) n_join[n]++;
      if (ovalid && oready) n_beat++;
      if (f_done) n_done++;
    end
    if (rst || clr) begin
      ph = 0; mcnt = 0; mlim = 0; miss = 0; mov = 0; mod = '0;
    end else begin
      case (ph)
        0: if (cclr) mcnt = 0;
           else if (cstart) begin
             mlim = int'(climit); mcnt = 0; miss = 0; ph = (climit == 0) ? 2 : 1;
           end
        1: if (cclr) begin ph = 0; mov = 0; end
           else begin
             kl = cen && in_valid[0] && in_valid[1] && in_valid[2] && (miss < mlim)
                  && (!mov || oready);
             bt = mov && oready;
             if (kl) miss++;
             if (bt) mcnt++;
             if (bt && mcnt == mlim) begin ph = 2; mov = 0; end
             else if (kl) begin mov = 1; mod = in_data[0] + in_data[1] + in_data[2]; end
             else if (bt) mov = 0;
           end
        default: begin ph = 0; if (cclr) mcnt = 0; end
      endcase
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_job(input int l);
    climit = 16'(l); cstart = 1; step(); cstart = 0;
  endtask

  task automatic wait_done(input string nm);
    int d0 = n_done;
    int k = 0;
    while (n_done == d0 && k < 60) begin step(); k++; end
    chk(nm, n_done - d0, 1);
  endtask

  task automatic wait_cnt(input int c);
    int k = 0;
    while (f_cnt != 16'(c) && k < 60) begin step(); k++; end
    chk("wait_cnt", f_cnt, c);
  endtask

  int j0, j1, j2, b0, d0;
  logic [31:0] hold;

  initial begin
    rst = 1; clr = 0; cstart = 0; cclr = 0; cen = 1; oready = 1; climit = '0;
    for (int n = 0; n < 3; n++) in_valid[n] = 1;
    step(); step();
    rst = 0; chk_en = 1;
    chk("rst_ready", f_ready, 1);
    chk("rst_cnt", f_cnt, 0);
    chk("rst_ovalid", ovalid, 0);
    chk("rst_odata", odata, 0);

    // Limit 4, everything flowing: 4 joins, 4 beats, one done pulse.
    j0 = n_join[0]; j1 = n_join[1]; j2 = n_join[2]; b0 = n_beat; d0 = n_done;
    start_job(4);
    wait_done("t1_done");
    step(); step();
    chk("t1_joins0", n_join[0] - j0, 4);
    chk("t1_joins1", n_join[1] - j1, 4);
    chk("t1_joins2", n_join[2] - j2, 4);
    chk("t1_beats", n_beat - b0, 4);
    chk("t1_pulses", n_done - d0, 1);
    chk("t1_cnt", f_cnt, 4);
    chk("t1_ready", f_ready, 1);
    chk("t1_last_data", odata, 32'(1003 + 2003 + 3003));

    // in1 starved for 3 cycles: nothing consumed from any stream.
    start_job(4);
    step();
    in_valid[1] = 0;
    j0 = n_join[0]; j1 = n_join[1]; j2 = n_join[2];
    repeat (3) step();
    chk("t2_stall0", n_join[0] - j0, 0);
    chk("t2_stall1", n_join[1] - j1, 0);
    chk("t2_stall2", n_join[2] - j2, 0);
    in_valid[1] = 1;
    wait_done("t2_done");
    chk("t2_cnt", f_cnt, 4);
    chk("t2_lockstep", n_join[0] - n_join[2], 0);

    // Sink backpressure for 5 cycles with a result held.
    start_job(3);
    step(); step();
    oready = 0; hold = odata;
    chk("t3_held", ovalid, 1);
    repeat (5) step();
    chk("t3_data_stable", odata, hold);
    chk("t3_cnt_hold", f_cnt, 1);
    chk("t3_kor", kor, 0);
    oready = 1;
    wait_done("t3_done");
    chk("t3_cnt", f_cnt, 3);

    // Limit 0: done the very next cycle, no traffic.
    j0 = n_join[0]; b0 = n_beat;
    start_job(0);
    chk("t4_done_now", f_done, 1);
    step();
    chk("t4_done_gone", f_done, 0);
    chk("t4_ready", f_ready, 1);
    chk("t4_joins", n_join[0] - j0, 0);
    chk("t4_beats", n_beat - b0, 0);
    chk("t4_cnt", f_cnt, 0);

    // Abort after 2 of 8 beats, then a normal 3-beat job.
    start_job(8);
    wait_cnt(2);
    d0 = n_done;
    cclr = 1; step(); cclr = 0;
    chk("t5_ovalid", ovalid, 0);
    chk("t5_ready", f_ready, 1);
    chk("t5_cnt", f_cnt, 2);
    step(); step();
    chk("t5_no_done", n_done - d0, 0);
    start_job(3);
    wait_done("t5_done");
    chk("t5_cnt3", f_cnt, 3);

    // Reset mid-job discards it silently.
    start_job(6);
    wait_cnt(2);
    d0 = n_done;
    rst = 1; step(); rst = 0;
    chk("t6_ready", f_ready, 1);
    chk("t6_cnt", f_cnt, 0);
    chk("t6_ovalid", ovalid, 0);
    chk("t6_odata", odata, 0);
    chk("t6_done", f_done, 0);
    step(); step();
    chk("t6_no_done", n_done - d0, 0);

    // A start during RUN is ignored: the job runs to its original limit.
    start_job(5);
    wait_cnt(1);
    climit = 16'd2; cstart = 1; step(); cstart = 0;
    wait_done("t7_done");
    chk("t7_cnt", f_cnt, 5);

    // Enable low: held result drains, no new loads.
    start_job(3);
    step(); step();
    cen = 0;
    b0 = n_beat; j0 = n_join[0];
    repeat (3) step();
    chk("t8_drain", n_beat - b0, 1);
    chk("t8_no_join", n_join[0] - j0, 0);
    cen = 1;
    wait_done("t8_done");
    chk("t8_cnt", f_cnt, 3);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
